sal_ddr2_cmd_sched: RTL and testbench
=====================================

# sal_ddr2_cmd_sched

DDR2 command scheduler: the grant side of the per-bank scheduling handshake (act/rd/wr/pre/ref request → grant). It arbitrates the requests of all bank controllers and enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW). Each cycle it grants at most one command, except the all-bank REF, and drives that command onto the DFI control bus one cycle later.

## Interface
- NUM_BANK, 4, number of bank controllers served.
- RA_W, 14, row address width.
- CA_W, 10, column address width.
- BA_W, 2, bank address width (log2 NUM_BANK).
- clk  in  1  controller clock.
- rst_n  in  1  asynchronous active-low reset.
- act_req_i / rd_req_i / wr_req_i / pre_req_i / ref_req_i  in  NUM_BANK each  per-bank command requests.
- ra_i  in  NUM_BANK*RA_W  per-bank row address (bank b at [b*RA_W +: RA_W]).
- ca_i  in  NUM_BANK*CA_W  per-bank column address.
- act_gnt_o / rd_gnt_o / wr_gnt_o / pre_gnt_o / ref_gnt_o  out  NUM_BANK each  per-bank grants.
- t_rrd_i  in  4  ACT→ACT cycles, any banks.
- t_ccd_i  in  3  CAS→CAS cycles.
- t_wtr_i  in  5  WR→RD cycles (software includes WL + BL/2).
- t_rtw_i  in  5  RD→WR cycles.
- dfi_cs_n / dfi_ras_n / dfi_cas_n / dfi_we_n  out  1 each  DFI command.
- dfi_address  out  RA_W  row, or column with A10=0.
- dfi_bank  out  BA_W  target bank.

## Operation
- Grants are combinational from the current requests and counter state, asserted for one cycle. A bank holds its request until granted and drops or advances it in the following cycle.
- Class priority: REF > CAS (RD/WR) > ACT > PRE.
- REF is eligible only when ref_req_i is all ones. All ref_gnt_o bits assert together; no other grant fires in that cycle.
- Within a class, banks are picked round-robin. A single pointer moves to the granted bank +1 (mod NUM_BANK) on any grant. REF does not move the pointer.
- Eligibility gates (counter == 0):
  - ACT: rrd_cnt.
  - RD: ccd_cnt and wtr_cnt.
  - WR: ccd_cnt and rtw_cnt.
  - PRE, REF: no gate here. tRP, tRAS and tRFC belong to the bank controllers.
- A class with no eligible request yields to the next class in the same cycle; a blocked higher class does not stall lower classes.
- Counter loads on a grant (value t-1; t=0 treated as 1):
  - ACT loads rrd_cnt.
  - RD loads ccd_cnt and rtw_cnt.
  - WR loads ccd_cnt and wtr_cnt.
- Nonzero counters decrement every cycle and saturate at 0.
- DFI encoding (cs,ras,cas,we):
  - ACT = 0011, address = ra.
  - RD = 0101, address = ca with A10=0.
  - WR = 0100, address = ca with A10=0.
  - PRE = 0010, A10=0.
  - REF = 0001, address 0, bank 0.
  - NOP = 0111 with address and bank held.
- CA_W < RA_W: zero-extend the column, then force A10=0.

## Timing
- Command appears on the DFI outputs in the cycle after its grant (registered).
- Reset values:
  - All grants 0.
  - dfi_cs_n = 1 and ras/cas/we = 1 (deselect).
  - Address and bank 0.
  - All counters 0 and RR pointer 0.
- After reset release, NOP is driven from the first clock edge.
- t=1 allows back-to-back commands of that class.
- A request already granted but still asserted the next cycle is treated as a new request. Banks must not do this.
- Reset mid-command: the DFI output returns to deselect immediately (async) and counters clear.

## Structure
- Command encodings (cmd_t enum NOP/ACT/RD/WR/PRE/REF) go in a shared package sal_ddr2_pkg. Widths come from SAL_DDR2_PARAMS.svh.
- Sub-module sal_rr_arbiter (NUM_BANK request vector + pointer → one-hot grant) is instantiated once per class, all sharing one pointer.

## Test plan
- Reset, then single ACT from bank 2 with ra=0x1A5 → act_gnt_o=4'b0100 same cycle; next cycle dfi cs/ras/cas/we=0011, address 0x1A5, bank 2.
- t_rrd=4, ACT from banks 0 and 1 simultaneously → bank 0 granted at T; bank 1 granted at T+4, not earlier.
- t_ccd=2, t_wtr=6: WR bank 0 at T, RD bank 1 pending → RD granted at T+6; RD after RD granted at +2.
- RD pending but blocked by tWTR while ACT pending on another bank → ACT granted the same cycle.
- ref_req_i=4'b0111 → no REF grant; set to 4'b1111 → all ref_gnt_o high, DFI 0001 next cycle.
- Four banks request RD continuously with t_ccd=1 → grants rotate 0,1,2,3,0; assert rst_n low mid-stream → dfi_cs_n=1 asynchronously.

Source files
------------

// File: rtl/sal_ddr2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sal_ddr2_pkg
// Description : Shared widths, DFI command encodings and helpers for the
//               DDR2 command scheduler.
//               Contents:
//                 SAL_NUM_BANK/RA_W/CA_W/BA_W : default geometry
//                 cmd_t                       : scheduler command selector
//                 DFI_DESEL                   : {cs,ras,cas,we} while deselected
//                 cmd_to_dfi()                : cmd_t -> {cs,ras,cas,we}
// Revision    : 1.0 - initial release
// ============================================================================
package sal_ddr2_pkg;

  localparam int SAL_NUM_BANK = 4;
  localparam int SAL_RA_W     = 14;
  localparam int SAL_CA_W     = 10;
  localparam int SAL_BA_W     = 2;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  localparam logic [3:0] DFI_DESEL = 4'b1111;

  // Active-low {cs_n, ras_n, cas_n, we_n} for each command.
  function automatic logic [3:0] cmd_to_dfi(input cmd_t cmd);
    logic [3:0] enc;
    case (cmd)
      CMD_ACT: enc = 4'b0011;
      CMD_RD:  enc = 4'b0101;
      CMD_WR:  enc = 4'b0100;
      CMD_PRE: enc = 4'b0010;
      CMD_REF: enc = 4'b0001;
      default: enc = 4'b0111;
    endcase
    return enc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sal_ddr2_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sal_ddr2_cmd_sched_if
// Description : Per-bank request/grant handshake between the bank controllers
//               and the command scheduler.
//               Signals:
//                 *_req_i : per-bank ACT/RD/WR/PRE/REF requests (bank -> sched)
//                 ra_i    : per-bank row address, bank b at [b*RA_W +: RA_W]
//                 ca_i    : per-bank column address, bank b at [b*CA_W +: CA_W]
//                 *_gnt_o : per-bank one-cycle grants (sched -> bank)
//               Modports: master = bank side, slave = scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sal_ddr2_cmd_sched_if
  import sal_ddr2_pkg::*;
#(
  parameter int NUM_BANK = SAL_NUM_BANK,
  parameter int RA_W     = SAL_RA_W,
  parameter int CA_W     = SAL_CA_W
);
  logic [NUM_BANK-1:0]      act_req_i;
  logic [NUM_BANK-1:0]      rd_req_i;
  logic [NUM_BANK-1:0]      wr_req_i;
  logic [NUM_BANK-1:0]      pre_req_i;
  logic [NUM_BANK-1:0]      ref_req_i;
  logic [NUM_BANK*RA_W-1:0] ra_i;
  logic [NUM_BANK*CA_W-1:0] ca_i;
  logic [NUM_BANK-1:0]      act_gnt_o;
  logic [NUM_BANK-1:0]      rd_gnt_o;
  logic [NUM_BANK-1:0]      wr_gnt_o;
  logic [NUM_BANK-1:0]      pre_gnt_o;
  logic [NUM_BANK-1:0]      ref_gnt_o;

  modport master (
    output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
    input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o
  );

  modport slave (
    input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
    output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o
  );
endinterface
`default_nettype wire

// File: rtl/sal_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sal_rr_arbiter
// Description : Round-robin picker. Grants the first requester found scanning
//               upward from ptr, wrapping at NUM_BANK.
//               Ports:
//                 req     in  NUM_BANK  request vector
//                 ptr     in  BA_W      highest-priority bank this cycle
//                 gnt     out NUM_BANK  one-hot grant (zero if no request)
//                 gnt_idx out BA_W      index of the granted bank
//                 any     out 1         some request was granted
// Revision    : 1.0 - initial release
// ============================================================================
module sal_rr_arbiter #(
  parameter int NUM_BANK = 4,
  parameter int BA_W     = 2
) (
  input  logic [NUM_BANK-1:0] req,
  input  logic [BA_W-1:0]     ptr,
  output logic [NUM_BANK-1:0] gnt,
  output logic [BA_W-1:0]     gnt_idx,
  output logic                any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_BANK; i++) begin
      idx = (int'(ptr) + i) % NUM_BANK;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = BA_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sal_ddr2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : sal_ddr2_cmd_sched
// Description : DDR2 command scheduler. Arbitrates per-bank requests with
//               class priority REF > CAS > ACT > PRE, round-robin inside a
//               class, enforces tRRD/tCCD/tWTR/tRTW and drives the granted
//               command onto the DFI control bus one cycle later.
//               Ports:
//                 clk, rst_n          clock, async active-low reset
//                 bus (slave)         request/grant handshake
//                 t_rrd_i..t_rtw_i    inter-bank timing in cycles
//                 dfi_*               registered DFI command/address/bank
// Revision    : 1.0 - initial release
// ============================================================================
module sal_ddr2_cmd_sched
  import sal_ddr2_pkg::*;
#(
  parameter int NUM_BANK = SAL_NUM_BANK,
  parameter int RA_W     = SAL_RA_W,
  parameter int CA_W     = SAL_CA_W,
  parameter int BA_W     = SAL_BA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  sal_ddr2_cmd_sched_if.slave bus,
  input  logic [3:0]          t_rrd_i,
  input  logic [2:0]          t_ccd_i,
  input  logic [4:0]          t_wtr_i,
  input  logic [4:0]          t_rtw_i,
  output logic                dfi_cs_n,
  output logic                dfi_ras_n,
  output logic                dfi_cas_n,
  output logic                dfi_we_n,
  output logic [RA_W-1:0]     dfi_address,
  output logic [BA_W-1:0]     dfi_bank
);

  logic [3:0]          rrd_cnt;
  logic [2:0]          ccd_cnt;
  logic [4:0]          wtr_cnt;
  logic [4:0]          rtw_cnt;
  logic [BA_W-1:0]     rr_ptr;
  logic [3:0]          dfi_cmd;

  logic [NUM_BANK-1:0] rd_elig, wr_elig, act_elig;
  logic [NUM_BANK-1:0] cas_gnt, act_gnt, pre_gnt;
  logic [BA_W-1:0]     cas_idx, act_idx, pre_idx;
  logic                cas_any, act_any, pre_any;

  logic [NUM_BANK-1:0] act_g, rd_g, wr_g, pre_g, ref_g;
  cmd_t                cmd;
  logic [BA_W-1:0]     sel_idx;
  logic [CA_W-1:0]     ca_sel;
  logic [RA_W-1:0]     ra_sel, cas_addr;

  // Blocked classes are masked here so that they yield to lower classes.
  assign rd_elig  = bus.rd_req_i  & {NUM_BANK{(ccd_cnt == '0) && (wtr_cnt == '0)}};
  assign wr_elig  = bus.wr_req_i  & {NUM_BANK{(ccd_cnt == '0) && (rtw_cnt == '0)}};
  assign act_elig = bus.act_req_i & {NUM_BANK{rrd_cnt == '0}};

  // RD and WR form one CAS class and share a single round-robin pick.
  sal_rr_arbiter #(.NUM_BANK(NUM_BANK), .BA_W(BA_W)) u_cas_arb (
    .req(rd_elig | wr_elig), .ptr(rr_ptr), .gnt(cas_gnt), .gnt_idx(cas_idx), .any(cas_any)
  );
  sal_rr_arbiter #(.NUM_BANK(NUM_BANK), .BA_W(BA_W)) u_act_arb (
    .req(act_elig), .ptr(rr_ptr), .gnt(act_gnt), .gnt_idx(act_idx), .any(act_any)
  );
  sal_rr_arbiter #(.NUM_BANK(NUM_BANK), .BA_W(BA_W)) u_pre_arb (
    .req(bus.pre_req_i), .ptr(rr_ptr), .gnt(pre_gnt), .gnt_idx(pre_idx), .any(pre_any)
  );

  // Grants are suppressed while reset is held so no bank sees a grant
  // whose command never reaches the DFI.
  always_comb begin
    act_g   = '0;
    rd_g    = '0;
    wr_g    = '0;
    pre_g   = '0;
    ref_g   = '0;
    cmd     = CMD_NOP;
    sel_idx = '0;
    if (!rst_n) begin
      cmd = CMD_NOP;
    end else if (&bus.ref_req_i) begin
      ref_g = '1;
      cmd   = CMD_REF;
    end else if (cas_any) begin
      sel_idx = cas_idx;
      if (rd_elig[cas_idx]) begin
        rd_g = cas_gnt;
        cmd  = CMD_RD;
      end else begin
        wr_g = cas_gnt;
        cmd  = CMD_WR;
      end
    end else if (act_any) begin
      act_g   = act_gnt;
      sel_idx = act_idx;
      cmd     = CMD_ACT;
    end else if (pre_any) begin
      pre_g   = pre_gnt;
      sel_idx = pre_idx;
      cmd     = CMD_PRE;
    end
  end

  assign bus.act_gnt_o = act_g;
  assign bus.rd_gnt_o  = rd_g;
  assign bus.wr_gnt_o  = wr_g;
  assign bus.pre_gnt_o = pre_g;
  assign bus.ref_gnt_o = ref_g;

  // Column is zero-extended to the row width, then A10 (auto-precharge) cleared.
  assign ra_sel   = bus.ra_i[int'(sel_idx)*RA_W +: RA_W];
  assign ca_sel   = bus.ca_i[int'(sel_idx)*CA_W +: CA_W];
  assign cas_addr = RA_W'(ca_sel) & ~(RA_W'(1) << 10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt     <= '0;
      ccd_cnt     <= '0;
      wtr_cnt     <= '0;
      rtw_cnt     <= '0;
      rr_ptr      <= '0;
      dfi_cmd     <= DFI_DESEL;
      dfi_address <= '0;
      dfi_bank    <= '0;
    end else begin
      // A timing value of 0 behaves like 1: load t-1, floored at 0.
      if (cmd == CMD_ACT)      rrd_cnt <= (t_rrd_i == '0) ? 4'd0 : t_rrd_i - 4'd1;
      else if (rrd_cnt != '0)  rrd_cnt <= rrd_cnt - 4'd1;

      if (cmd == CMD_RD || cmd == CMD_WR) ccd_cnt <= (t_ccd_i == '0) ? 3'd0 : t_ccd_i - 3'd1;
      else if (ccd_cnt != '0)             ccd_cnt <= ccd_cnt - 3'd1;

      if (cmd == CMD_WR)       wtr_cnt <= (t_wtr_i == '0) ? 5'd0 : t_wtr_i - 5'd1;
      else if (wtr_cnt != '0)  wtr_cnt <= wtr_cnt - 5'd1;

      if (cmd == CMD_RD)       rtw_cnt <= (t_rtw_i == '0) ? 5'd0 : t_rtw_i - 5'd1;
      else if (rtw_cnt != '0)  rtw_cnt <= rtw_cnt - 5'd1;

      // REF is all-bank, so it leaves the fairness pointer alone.
      if (cmd != CMD_NOP && cmd != CMD_REF)
        rr_ptr <= BA_W'((int'(sel_idx) + 1) % NUM_BANK);

      dfi_cmd <= cmd_to_dfi(cmd);
      case (cmd)
        CMD_ACT: begin
          dfi_address <= ra_sel;
          dfi_bank    <= sel_idx;
        end
        CMD_RD, CMD_WR: begin
          dfi_address <= cas_addr;
          dfi_bank    <= sel_idx;
        end
        CMD_PRE: begin
          dfi_address <= '0;
          dfi_bank    <= sel_idx;
        end
        CMD_REF: begin
          dfi_address <= '0;
          dfi_bank    <= '0;
        end
        default: begin
          dfi_address <= dfi_address;
          dfi_bank    <= dfi_bank;
        end
      endcase
    end
  end

  assign {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} = dfi_cmd;

endmodule
`default_nettype wire

// File: tb/tb_sal_ddr2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sal_ddr2_cmd_sched
// Description : Self-checking bench for sal_ddr2_cmd_sched. A vector table
//               covers class priority, round-robin and DFI encoding; short
//               hand-written sequences cover tRRD, tCCD/tWTR, class yielding,
//               RD rotation and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sal_ddr2_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] t_rrd;
  logic [2:0] t_ccd;
  logic [4:0] t_wtr, t_rtw;
  logic       dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [13:0] dfi_address;
  logic [1:0]  dfi_bank;

  int tests = 0;
  int fails = 0;

  sal_ddr2_cmd_sched_if bus ();

  sal_ddr2_cmd_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .t_rrd_i     (t_rrd),
    .t_ccd_i     (t_ccd),
    .t_wtr_i     (t_wtr),
    .t_rtw_i     (t_rtw),
    .dfi_cs_n    (dfi_cs_n),
    .dfi_ras_n   (dfi_ras_n),
    .dfi_cas_n   (dfi_cas_n),
    .dfi_we_n    (dfi_we_n),
    .dfi_address (dfi_address),
    .dfi_bank    (dfi_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  act, rd, wr, pre, rf;
    logic [19:0] exp_gnt;   // {act, rd, wr, pre, ref}
    logic [3:0]  exp_dfi;
    logic [1:0]  exp_bank;
    logic [13:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic set_req(input logic [3:0] act, input logic [3:0] rd, input logic [3:0] wr,
                         input logic [3:0] pre, input logic [3:0] rf);
    bus.act_req_i = act;
    bus.rd_req_i  = rd;
    bus.wr_req_i  = wr;
    bus.pre_req_i = pre;
    bus.ref_req_i = rf;
  endtask

  function automatic logic [19:0] gnts();
    return {bus.act_gnt_o, bus.rd_gnt_o, bus.wr_gnt_o, bus.pre_gnt_o, bus.ref_gnt_o};
  endfunction

  function automatic logic [3:0] dfi();
    return {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
  endfunction

  initial begin
    // Round-robin pointer evolution through the table: 0,3,1,3,1,0,2,2,3,0.
    vecs[0] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, {4'b0100, 16'h0000}, 4'b0011, 2'd2, 14'h01A5};
    vecs[1] = '{4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, {4'b0000, 4'b0001, 12'h000}, 4'b0101, 2'd0, 14'h03FF};
    vecs[2] = '{4'b0010, 4'b0000, 4'b0101, 4'b0000, 4'b0000, {8'h00, 4'b0100, 8'h00}, 4'b0100, 2'd2, 14'h0155};
    vecs[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0000, {4'b0001, 16'h0000}, 4'b0011, 2'd0, 14'h0111};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, {12'h000, 4'b1000, 4'b0000}, 4'b0010, 2'd3, 14'h0000};
    vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0111, {12'h000, 4'b0010, 4'b0000}, 4'b0010, 2'd1, 14'h0000};
    vecs[6] = '{4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b1111, {16'h0000, 4'b1111}, 4'b0001, 2'd0, 14'h0000};
    vecs[7] = '{4'b0000, 4'b1001, 4'b0110, 4'b0000, 4'b0000, {8'h00, 4'b0100, 8'h00}, 4'b0100, 2'd2, 14'h0155};
    vecs[8] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, {4'b0000, 4'b1000, 12'h000}, 4'b0101, 2'd3, 14'h02AA};
    vecs[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 20'h00000, 4'b0111, 2'd3, 14'h02AA};

    rst_n = 1'b0;
    t_rrd = 4'd1; t_ccd = 3'd1; t_wtr = 5'd1; t_rtw = 5'd1;
    set_req(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    bus.ra_i = {14'h3FFF, 14'h01A5, 14'h0222, 14'h0111};
    bus.ca_i = {10'h2AA, 10'h155, 10'h012, 10'h3FF};

    // Reset state, then NOP from the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt",  32'(gnts()), 32'h0);
    chk("reset_dfi",  32'(dfi()), 32'hF);
    chk("reset_addr", 32'(dfi_address), 32'h0);
    chk("reset_bank", 32'(dfi_bank), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_nop", 32'(dfi()), 32'h7);

    // Table vectors: grant checked mid-cycle, DFI checked after the edge.
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].act, vecs[i].rd, vecs[i].wr, vecs[i].pre, vecs[i].rf);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(gnts()), 32'(vecs[i].exp_gnt));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dfi", i),  32'(dfi()), 32'(vecs[i].exp_dfi));
      chk($sformatf("vec%0d_bank", i), 32'(dfi_bank), 32'(vecs[i].exp_bank));
      chk($sformatf("vec%0d_addr", i), 32'(dfi_address), 32'(vecs[i].exp_addr));
    end
    set_req(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // tRRD=4: bank 0 at T, bank 1 not before T+4. Pointer is 0 here.
    t_rrd = 4'd4;
    set_req(4'b0011, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    chk("rrd_first", 32'(bus.act_gnt_o), 32'h1);
    @(posedge clk); #1;
    bus.act_req_i = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rrd_t%0d", k), 32'(bus.act_gnt_o), (k == 4) ? 32'h2 : 32'h0);
      @(posedge clk); #1;
    end
    set_req(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    t_rrd = 4'd1;
    repeat (5) @(posedge clk);
    #1;

    // tCCD=2, tWTR=6: WR bank 0 at T with RD bank 1 pending; ACT bank 3 slips
    // in at T+1 while RD is blocked; RD at T+6; next RD (bank 2) at +2.
    t_ccd = 3'd2; t_wtr = 5'd6;
    set_req(4'b0, 4'b0010, 4'b0001, 4'b0, 4'b0);
    @(negedge clk);
    chk("wtr_wr_gnt", 32'(bus.wr_gnt_o), 32'h1);
    chk("wtr_rd_blk", 32'(bus.rd_gnt_o), 32'h0);
    @(posedge clk); #1;
    bus.wr_req_i  = 4'b0;
    bus.act_req_i = 4'b1000;
    @(negedge clk);
    chk("yield_act", 32'(bus.act_gnt_o), 32'h8);
    chk("yield_rd",  32'(bus.rd_gnt_o), 32'h0);
    @(posedge clk); #1;
    bus.act_req_i = 4'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("wtr_t%0d", k), 32'(bus.rd_gnt_o), (k == 6) ? 32'h2 : 32'h0);
      @(posedge clk); #1;
    end
    bus.rd_req_i = 4'b0100;
    @(negedge clk);
    chk("ccd_t7", 32'(bus.rd_gnt_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ccd_t8", 32'(bus.rd_gnt_o), 32'h4);
    @(posedge clk); #1;
    set_req(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    t_ccd = 3'd1; t_wtr = 5'd1;

    // Reset clears the pointer; four continuous RD requesters rotate 0,1,2,3,0.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rd_req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rot_%0d", k), 32'(bus.rd_gnt_o), 32'(1 << (k % 4)));
      @(posedge clk); #1;
    end
    chk("rot_dfi",  32'(dfi()), 32'h5);
    chk("rot_bank", 32'(dfi_bank), 32'h0);

    // Asynchronous reset mid-stream: deselect without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dfi",  32'(dfi()), 32'hF);
    chk("async_gnt",  32'(gnts()), 32'h0);
    chk("async_addr", 32'(dfi_address), 32'h0);
    @(posedge clk); #1;
    set_req(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
